mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single-port memory (clk, reset, addr, wr_en, rd_en,
//   wdata, rdata) between NUM_REQ requesters. Sits between requester agents/masters and the
//   memory instance. Serialises accesses through a 2-state FSM and routes read data back to
//   the granted requester.
// PARAMETERS
//   NUM_REQ  2   number of requesters (2..8)
//   ADDR_W   2   memory address width
//   DATA_W   8   memory data width
// PORTS
//   clk        in   1               clock, rising edge
//   reset      in   1               asynchronous, active-low reset
//   req        in   NUM_REQ         per-requester request, level; held until gnt seen
//   req_wr     in   NUM_REQ         1=write, 0=read; valid while req high
//   req_addr   in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        out  NUM_REQ         one-hot, 1-cycle pulse: request i issued this cycle
//   rsp_valid  out  NUM_REQ         one-hot, 1-cycle pulse: read data for requester i valid
//   rsp_rdata  out  DATA_W          read data, = mem_rdata; qualified by rsp_valid
//   mem_addr   out  ADDR_W          to memory addr
//   mem_wr_en  out  1               to memory wr_en
//   mem_rd_en  out  1               to memory rd_en
//   mem_wdata  out  DATA_W          to memory wdata
//   mem_rdata  in   DATA_W          from memory rdata (memory registers it 1 cycle after rd_en)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, gnt=0, rsp_valid=0, mem_wr_en=mem_rd_en=0,
//     mem_addr=0, mem_wdata=0, rr pointer=NUM_REQ-1 (requester 0 wins first), read pending cleared.
//   - FSM IDLE: if |req, select winner w = first set req bit searching from ptr+1 upward, wrapping
//     modulo NUM_REQ; register mem_addr/mem_wdata/mem_wr_en=req_wr[w]/mem_rd_en=~req_wr[w],
//     gnt[w]=1, ptr<=w, go ISSUE. If no req: stay IDLE, all enables 0.
//   - FSM ISSUE: memory strobes driven for exactly this cycle, gnt[w]=1; next state always IDLE.
//     Requester drops req (or presents a new one) on the cycle after gnt.
//   - Throughput: max one access per 2 cycles. Latency req->gnt = 1 cycle from an IDLE sample.
//   - Read response: rsp_valid[w]=1 in the cycle after ISSUE (registered pending flag), rsp_rdata =
//     mem_rdata that cycle. Writes produce no rsp_valid.
//   - Never both mem_wr_en and mem_rd_en; at most one gnt bit and one rsp_valid bit high.
//   - req bits that drop before being granted are simply not served (no error).
//   - Wrap: ptr=NUM_REQ-1 searches from 0. Single active requester is granted every 2 cycles.
//   - Reset in ISSUE: strobes and gnt go 0 immediately; pending read discarded, no rsp_valid.
//   - rsp_valid may coincide with a new IDLE arbitration decision; both are legal in one cycle.
// CONFIGURATION
//   MEM_ARB_STATS_EN defined: adds output grant_cnt [NUM_REQ*16-1:0]; 16-bit per-requester
//     counter incremented on each gnt[i] pulse, saturates at 16'hFFFF, cleared by reset.
//   Not defined: port and counters absent; all other behaviour identical.
// TESTING
//   1. Reset, req[0]=1 wr addr=2 wdata=8'hA5 -> gnt[0] pulse 2nd edge, mem_wr_en=1 addr=2 one cycle.
//   2. After 1, req[1]=1 rd addr=2 -> gnt[1], mem_rd_en=1; next cycle rsp_valid=2'b10 rsp_rdata=8'hA5.
//   3. req=2'b11 held after reset -> gnt order 0,1,0,1; gnt pulses every 2 cycles, no starvation.
//   4. Only req[1] held 10 cycles -> gnt[1] on alternate cycles, gnt[0]=0 throughout.
//   5. Assert reset low during ISSUE of a read -> strobes/gnt 0 at once, no rsp_valid; after
//      release requester 0 wins first.
//   6. MEM_ARB_STATS_EN: 3 grants to req 0, 2 to req 1 -> grant_cnt = {16'd2,16'd3}; reset -> 0.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter that shares one single-port memory between
// NUM_REQ requesters. A two-state FSM (IDLE/ISSUE) serialises accesses to at most one
// every two cycles. Read data is routed back to the requester that issued the read.
// Optional build macro MEM_ARB_STATS_EN adds per-requester saturating grant counters
// on output grant_cnt.
//
//   state | meaning
//   IDLE  | arbitrating; on any request, register winner's access and pulse gnt
//   ISSUE | memory strobes and gnt asserted for this single cycle
module mem_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Winner search: first asserted request strictly after the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Arbitration FSM, registered memory strobes, grant and read-response flags.
    // rsp_valid doubles as the pending-read flag: it is set on the edge that ends ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= PTR_W'(NUM_REQ - 1);
            gnt       <= '0;
            rsp_valid <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        mem_addr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
                        mem_wr_en <= req_wr[win];
                        mem_rd_en <= ~req_wr[win];
                        gnt       <= NUM_REQ'(1) << win;
                        ptr       <= win;
                        state     <= ISSUE;
                    end
                end
                default: begin
                    if (mem_rd_en) rsp_valid <= gnt;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory registers its read data, so it is valid exactly when rsp_valid is.
    assign rsp_rdata = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed vector table, reset-in-ISSUE sequence, and randomized
// traffic checked against a transaction-level reference model of the arbiter.
module tb_mem_rr_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic [AW-1:0]        mem_addr;
    logic                 mem_wr_en;
    logic                 mem_rd_en;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [NREQ*16-1:0]   grant_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    mem_rr_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in single-port memory with registered read data.
    logic [DW-1:0] tb_mem [4];
    initial begin
        for (int i = 0; i < 4; i++) tb_mem[i] = DW'(8'h10 + i);
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
    end

    // Reference model: one transaction at a time, round-robin from last winner.
    logic [DW-1:0] ref_mem [4];
    bit            m_busy;
    int            m_ptr;
    int            m_owner;
    bit            m_wr, m_rd;
    int            m_addr;
    logic [DW-1:0] m_wdata;
    int            m_rsp;
    logic [DW-1:0] m_rdata;
    int            m_cnt [NREQ];

    task automatic model_reset();
        m_busy = 0; m_ptr = NREQ - 1; m_owner = -1; m_wr = 0; m_rd = 0;
        m_addr = 0; m_wdata = '0; m_rsp = -1; m_rdata = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        int  prev_owner = m_owner;
        bit  prev_rd    = m_rd;
        int  prev_addr  = m_addr;
        m_rsp = -1;
        if (m_busy) begin
            m_busy = 0; m_owner = -1; m_wr = 0; m_rd = 0;
            if (prev_rd) begin
                m_rsp   = prev_owner;
                m_rdata = ref_mem[prev_addr];
            end
        end else if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c = (m_ptr + k) % NREQ;
                if (req[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_busy  = 1;
            m_ptr   = m_owner;
            m_wr    = req_wr[m_owner];
            m_rd    = !req_wr[m_owner];
            m_addr  = int'(req_addr[m_owner*AW +: AW]);
            m_wdata = req_wdata[m_owner*DW +: DW];
            m_cnt[m_owner]++;
            if (m_wr) ref_mem[m_addr] = m_wdata;
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(int idx);
        logic [NREQ-1:0] v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, " gnt"}, 32'(gnt), 32'(onehot(m_owner)));
        check({tag, " wr_en"}, 32'(mem_wr_en), 32'(m_wr));
        check({tag, " rd_en"}, 32'(mem_rd_en), 32'(m_rd));
        if (m_wr || m_rd) check({tag, " addr"}, 32'(mem_addr), 32'(m_addr));
        if (m_wr) check({tag, " wdata"}, 32'(mem_wdata), 32'(m_wdata));
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(onehot(m_rsp)));
        if (m_rsp >= 0) check({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(m_rdata));
    endtask

    typedef struct {
        logic [1:0] rq, wr, a0, a1;
        logic [7:0] d0, d1;
        logic [1:0] e_gnt;
        logic       e_wr, e_rd;
        logic [1:0] e_addr;
        logic [7:0] e_wd;
        logic [1:0] e_rsp;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t tbl [20];

    initial begin
        for (int i = 0; i < 4; i++) ref_mem[i] = DW'(8'h10 + i);

        // Write A5 to addr 2, read it back, contention 0/1, then lone requester 1 writing.
        tbl[0]  = '{2'b01, 2'b01, 2'd2, 2'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 1'b0, 2'd2, 8'hA5, 2'b00, 8'h00};
        tbl[1]  = '{2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 2'b00, 8'h00};
        tbl[2]  = '{2'b10, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 2'd2, 8'h00, 2'b00, 8'h00};
        tbl[3]  = '{2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 2'b10, 8'hA5};
        tbl[4]  = '{2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 2'd0, 8'h00, 2'b00, 8'h00};
        tbl[5]  = '{2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 2'b01, 8'h10};
        tbl[6]  = '{2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 2'd1, 8'h00, 2'b00, 8'h00};
        tbl[7]  = '{2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 2'b10, 8'h11};
        tbl[8]  = '{2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 2'd0, 8'h00, 2'b00, 8'h00};
        tbl[9]  = '{2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 2'b01, 8'h10};
        for (int i = 10; i < 20; i++) begin
            if (i % 2 == 0)
                tbl[i] = '{2'b10, 2'b10, 2'd0, 2'd3, 8'h00, 8'h3C, 2'b10, 1'b1, 1'b0, 2'd3, 8'h3C, 2'b00, 8'h00};
            else
                tbl[i] = '{2'b10, 2'b10, 2'd0, 2'd3, 8'h00, 8'h3C, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 2'b00, 8'h00};
        end

        reset = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt", 32'(gnt), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset wr_en", 32'(mem_wr_en), 32'd0);
        check("reset rd_en", 32'(mem_rd_en), 32'd0);
        check("reset addr", 32'(mem_addr), 32'd0);
        check("reset wdata", 32'(mem_wdata), 32'd0);
`ifdef MEM_ARB_STATS_EN
        check("reset grant_cnt", 32'(grant_cnt), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            req       = tbl[i].rq;
            req_wr    = tbl[i].wr;
            req_addr  = {tbl[i].a1, tbl[i].a0};
            req_wdata = {tbl[i].d1, tbl[i].d0};
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
            check($sformatf("tbl%0d wr_en", i), 32'(mem_wr_en), 32'(tbl[i].e_wr));
            check($sformatf("tbl%0d rd_en", i), 32'(mem_rd_en), 32'(tbl[i].e_rd));
            if (tbl[i].e_wr || tbl[i].e_rd)
                check($sformatf("tbl%0d addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_wr)
                check($sformatf("tbl%0d wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wd));
            check($sformatf("tbl%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rsp));
            if (tbl[i].e_rsp != 2'b00)
                check($sformatf("tbl%0d rsp_rdata", i), 32'(rsp_rdata), 32'(tbl[i].e_rdata));
        end

`ifdef MEM_ARB_STATS_EN
        // Table grants: req0 x3 (rows 0,4,8), req1 x7 (rows 2,6,10..18).
        check("stats after table", 32'(grant_cnt), {16'd7, 16'd3});
`endif

        // Reset asserted mid-ISSUE of a read: everything drops at once, read is lost.
        req = 2'b01; req_wr = 2'b00; req_addr = {2'd0, 2'd1};
        model_step();
        @(posedge clk);
        #1;
        check("rstissue gnt", 32'(gnt), 32'b01);
        check("rstissue rd_en", 32'(mem_rd_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstasync gnt", 32'(gnt), 32'd0);
        check("rstasync rd_en", 32'(mem_rd_en), 32'd0);
        check("rstasync wr_en", 32'(mem_wr_en), 32'd0);
`ifdef MEM_ARB_STATS_EN
        check("rstasync grant_cnt", 32'(grant_cnt), 32'd0);
`endif
        model_reset();
        req = 2'b11; req_wr = 2'b00; req_addr = {2'd3, 2'd1};
        @(posedge clk);
        #1;
        check("inreset rsp_valid", 32'(rsp_valid), 32'd0);
        check("inreset gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        check("postrst first winner", 32'(gnt), 32'b01);
        check_model("postrst");
        model_step();
        @(posedge clk);
        #1;
        check_model("postrst2");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            req       = NREQ'($urandom);
            req_wr    = NREQ'($urandom);
            req_addr  = (NREQ*AW)'($urandom);
            req_wdata = (NREQ*DW)'($urandom);
            model_step();
            @(posedge clk);
            #1;
            check_model($sformatf("rnd%0d", n));
        end

`ifdef MEM_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check($sformatf("grant_cnt[%0d]", i), 32'(grant_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
